// File: rtl/systolic_output_collector_if.sv
// Column-result input bus and aligned-row output stream
// of the systolic output collector.
interface systolic_output_collector_if #(
  parameter int DATAWIDTH = 8,
  parameter int COLS      = 4
);
  localparam int W = 3 * DATAWIDTH;

  logic [COLS-1:0]   col_valid;
  logic [COLS*W-1:0] col_data;
  logic              out_valid;
  logic              out_ready;
  logic [COLS*W-1:0] out_data;

  modport master (
    output col_valid, col_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  col_valid, col_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/systolic_output_collector.sv
// Deskews bottom-row systolic outputs into full rows and
// buffers them in a small FIFO with a valid/ready output.
module systolic_output_collector #(
  parameter int DATAWIDTH  = 8,
  parameter int COLS       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  systolic_output_collector_if.slave bus,
  output logic        almost_full,
  output logic        overflow,
  output logic        skew_err,
  input  logic        clear_err,
  output logic [15:0] rows_out
);
  localparam int W  = 3 * DATAWIDTH;
  localparam int RW = COLS * W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [COLS-1:0] al_v;
  logic [RW-1:0]   al_d;

  // Column c waits COLS-1-c cycles so all columns of a row
  // line up with the live last column.
  for (genvar c = 0; c < COLS - 1; c++) begin : g_dl
    localparam int N = COLS - 1 - c;
    logic [N-1:0] v;
    logic [W-1:0] d [N];

    // Shift valid and data one stage per cycle, unconditionally.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v <= '0;
        for (int i = 0; i < N; i++) d[i] <= '0;
      end else begin
        v[0] <= bus.col_valid[c];
        d[0] <= bus.col_data[c*W +: W];
        for (int i = 1; i < N; i++) begin
          v[i] <= v[i-1];
          d[i] <= d[i-1];
        end
      end
    end

    assign al_v[c]       = v[N-1];
    assign al_d[c*W +: W] = d[N-1];
  end

  assign al_v[COLS-1] = bus.col_valid[COLS-1];
  assign al_d[(COLS-1)*W +: W] =
    bus.col_data[(COLS-1)*W +: W];

  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          all_v;
  logic          mixed;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // Row classification and FIFO push/pop decisions.
  always_comb begin
    all_v = &al_v;
    mixed = (|al_v) & ~all_v;
    full  = count == CW'(FIFO_DEPTH);
    pop   = bus.out_valid & bus.out_ready;
    push  = all_v & (~full | pop);
    drop  = all_v & full & ~pop;
  end

  assign bus.out_valid = count != '0;
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
  assign almost_full   = count >= CW'(FIFO_DEPTH - 1);

  // Row storage needs no reset: it is only read when count != 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= al_d;
  end

  // Pointers, occupancy, handoff counter and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rows_out <= '0;
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count + CW'(push) - CW'(pop);
      rows_out <= rows_out + 16'(pop);
      overflow <= (overflow & ~clear_err) | drop;
      skew_err <= (skew_err & ~clear_err) | mixed;
    end
  end
endmodule

// File: tb/tb_systolic_output_collector.sv
// Randomized and directed bench for systolic_output_collector
// against a row-level queue model.
module tb_systolic_output_collector;
  localparam int DW    = 8;
  localparam int COLS  = 4;
  localparam int DEPTH = 4;
  localparam int W     = 3 * DW;
  localparam int RW    = COLS * W;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_err;
  logic        almost_full;
  logic        overflow;
  logic        skew_err;
  logic [15:0] rows_out;

  systolic_output_collector_if #(
    .DATAWIDTH(DW), .COLS(COLS)
  ) bus ();

  systolic_output_collector #(
    .DATAWIDTH(DW), .COLS(COLS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .almost_full(almost_full),
    .overflow(overflow),
    .skew_err(skew_err),
    .clear_err(clear_err),
    .rows_out(rows_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [RW-1:0]   mq[$];
  bit              m_ovf;
  bit              m_skew;
  logic [15:0]     m_rows;
  bit [COLS-1:0]   im[int];
  logic [RW-1:0]   id[int];

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int c = 0; c < COLS; c++) r[c*W +: W] = W'($urandom);
    return r;
  endfunction

  function automatic logic [RW-1:0] m_head();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction

  function automatic bit m_af();
    return mq.size() >= DEPTH - 1;
  endfunction

  function automatic void issue(int at, bit [COLS-1:0] mask,
                                logic [RW-1:0] data);
    im[at] = mask;
    id[at] = data;
  endfunction

  function automatic void model_reset();
    mq.delete();
    im.delete();
    id.delete();
    m_ovf  = 0;
    m_skew = 0;
    m_rows = '0;
  endfunction

  // One clock cycle: drive skewed columns for cycle cyc, then
  // apply the row-level rules at the edge ending it.
  task automatic tick();
    logic [COLS-1:0] v;
    logic [RW-1:0]   d;
    bit pop, push, mixed, ovf_ev;
    int k;
    logic [RW-1:0] kd;
    for (int c = 0; c < COLS; c++) begin
      if (im.exists(cyc - c)) begin
        bit [COLS-1:0] mk;
        logic [RW-1:0] dd;
        mk = im[cyc - c];
        dd = id[cyc - c];
        v[c] = mk[c];
        d[c*W +: W] = dd[c*W +: W];
      end else begin
        v[c] = 1'b0;
        d[c*W +: W] = W'($urandom);
      end
    end
    bus.col_valid = v;
    bus.col_data  = d;
    k     = cyc - (COLS - 1);
    pop   = (mq.size() != 0) && bus.out_ready;
    push  = 0;
    mixed = 0;
    kd    = '0;
    if (im.exists(k)) begin
      push  = &im[k];
      mixed = (|im[k]) && !push;
      kd    = id[k];
    end
    ovf_ev = push && (mq.size() == DEPTH) && !pop;
    @(posedge clk);
    #1;
    if (pop) begin
      void'(mq.pop_front());
      m_rows = m_rows + 16'd1;
    end
    if (push && !ovf_ev) mq.push_back(kd);
    m_ovf  = (m_ovf && !clear_err) || ovf_ev;
    m_skew = (m_skew && !clear_err) || mixed;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_err = 1'b0;
    bus.out_ready = 1'b0;
    bus.col_valid = '0;
    bus.col_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got=%b want=0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data got=%h want=0", bus.out_data);
    end
    n_checks++;
    if ({almost_full, overflow, skew_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=000",
               {almost_full, overflow, skew_err});
    end
    n_checks++;
    if (rows_out !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_rows got=%0d want=0", rows_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_single_row();
    logic [RW-1:0] row;
    int t0;
    row = {24'h000044, 24'h000033, 24'h000022, 24'h000011};
    bus.out_ready = 1'b0;
    t0 = cyc;
    issue(t0, '1, row);
    for (int i = 1; i <= COLS; i++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== (i == COLS)) begin
        n_fail++;
        $display("FAIL single_latency cyc=%0d got=%b want=%b",
                 i, bus.out_valid, (i == COLS));
      end
    end
    n_checks++;
    if (bus.out_data !== row) begin
      n_fail++;
      $display("FAIL single_data got=%h want=%h",
               bus.out_data, row);
    end
    bus.out_ready = 1'b1;
    tick();
    n_checks++;
    if (rows_out !== 16'd1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop got rows=%0d valid=%b want 1/0",
               rows_out, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] rows[8];
    int t0, idx, first, last;
    logic [15:0] base;
    base = rows_out;
    bus.out_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      rows[i] = rand_row();
      issue(t0 + i, '1, rows[i]);
    end
    idx = 0;
    first = -1;
    last = -1;
    repeat (8 + COLS + 2) begin
      tick();
      n_checks++;
      if (bus.out_valid !== (mq.size() != 0) ||
          bus.out_data !== m_head()) begin
        n_fail++;
        $display("FAIL b2b_model got=%b/%h want=%b/%h",
                 bus.out_valid, bus.out_data,
                 (mq.size() != 0), m_head());
      end
      if (bus.out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        last = cyc;
        n_checks++;
        if (idx >= 8 || bus.out_data !== rows[idx % 8]) begin
          n_fail++;
          $display("FAIL b2b_order idx=%0d got=%h want=%h",
                   idx, bus.out_data, rows[idx % 8]);
        end
        idx++;
      end
    end
    n_checks++;
    if (idx != 8 || last - first != 7) begin
      n_fail++;
      $display("FAIL b2b_count got=%0d span=%0d want=8 span=7",
               idx, last - first);
    end
    n_checks++;
    if (rows_out - base !== 16'd8 || overflow || skew_err) begin
      n_fail++;
      $display("FAIL b2b_rows got=%0d ovf=%b skew=%b want=8/0/0",
               rows_out - base, overflow, skew_err);
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] rows[5];
    logic [RW-1:0] got[$];
    int t0;
    bus.out_ready = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      rows[i] = rand_row();
      issue(t0 + i, '1, rows[i]);
    end
    repeat (5 + COLS) begin
      tick();
      n_checks++;
      if (almost_full !== m_af() || overflow !== m_ovf ||
          bus.out_data !== m_head()) begin
        n_fail++;
        $display("FAIL bp_model got af=%b ovf=%b d=%h want %b/%b/%h",
                 almost_full, overflow, bus.out_data,
                 m_af(), m_ovf, m_head());
      end
    end
    n_checks++;
    if (almost_full !== 1'b1 || overflow !== 1'b1 ||
        bus.out_data !== rows[0]) begin
      n_fail++;
      $display("FAIL bp_full got af=%b ovf=%b d=%h want 1/1/%h",
               almost_full, overflow, bus.out_data, rows[0]);
    end
    bus.out_ready = 1'b1;
    repeat (6) begin
      if (bus.out_valid === 1'b1) got.push_back(bus.out_data);
      tick();
    end
    n_checks++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL bp_drain got=%0d rows want=4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== rows[i]) begin
        n_fail++;
        $display("FAIL bp_row%0d got=%h want=%h",
                 i, got[i], rows[i]);
      end
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_clear got=%b want=0", overflow);
    end
  endtask

  task automatic test_full_pushpop();
    logic [RW-1:0] rows[5];
    logic [RW-1:0] got[$];
    int t0;
    bus.out_ready = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      rows[i] = rand_row();
      issue(t0 + i, '1, rows[i]);
    end
    while (cyc < t0 + 4 + COLS - 1) tick();
    n_checks++;
    if (almost_full !== 1'b1 || bus.out_data !== rows[0] ||
        mq.size() != 4) begin
      n_fail++;
      $display("FAIL fpp_pre got af=%b d=%h want 1/%h",
               almost_full, bus.out_data, rows[0]);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (overflow !== 1'b0 || almost_full !== 1'b1 ||
        bus.out_data !== rows[1]) begin
      n_fail++;
      $display("FAIL fpp_same got ovf=%b af=%b d=%h want 0/1/%h",
               overflow, almost_full, bus.out_data, rows[1]);
    end
    bus.out_ready = 1'b1;
    repeat (5) begin
      if (bus.out_valid === 1'b1) got.push_back(bus.out_data);
      tick();
    end
    n_checks++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL fpp_drain got=%0d rows want=4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== rows[i+1]) begin
        n_fail++;
        $display("FAIL fpp_row%0d got=%h want=%h",
                 i, got[i], rows[i+1]);
      end
    end
  endtask

  task automatic test_skew_err();
    logic [RW-1:0] r0, r1;
    logic [RW-1:0] got[$];
    int t0;
    bus.out_ready = 1'b1;
    r0 = rand_row();
    r1 = rand_row();
    t0 = cyc;
    issue(t0, 4'b1011, r0);
    issue(t0 + 1, '1, r1);
    repeat (COLS + 2) begin
      if (bus.out_valid === 1'b1) got.push_back(bus.out_data);
      tick();
    end
    n_checks++;
    if (skew_err !== 1'b1 || got.size() != 1) begin
      n_fail++;
      $display("FAIL skew_set got err=%b rows=%0d want 1/1",
               skew_err, got.size());
    end
    n_checks++;
    if (got.size() == 0 || got[0] !== r1) begin
      n_fail++;
      $display("FAIL skew_next got=%h want=%h",
               (got.size() != 0) ? got[0] : '0, r1);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_checks++;
    if (skew_err !== 1'b0) begin
      n_fail++;
      $display("FAIL skew_clear got=%b want=0", skew_err);
    end
    t0 = cyc;
    issue(t0, 4'b0111, rand_row());
    issue(t0 + 1, 4'b0001, rand_row());
    while (cyc < t0 + COLS) begin
      clear_err = (cyc == t0 + COLS - 1) ? 1'b0 : 1'b0;
      tick();
    end
    n_checks++;
    if (skew_err !== 1'b1) begin
      n_fail++;
      $display("FAIL skew_reset got=%b want=1", skew_err);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_checks++;
    if (skew_err !== 1'b1) begin
      n_fail++;
      $display("FAIL skew_clear_race got=%b want=1", skew_err);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_checks++;
    if (skew_err !== 1'b0) begin
      n_fail++;
      $display("FAIL skew_clear2 got=%b want=0", skew_err);
    end
  endtask

  task automatic test_random();
    repeat (400) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) issue(cyc, '1, rand_row());
      else if (r == 7)
        issue(cyc, COLS'($urandom), rand_row());
      bus.out_ready = 1'($urandom_range(0, 1));
      clear_err = ($urandom_range(0, 9) == 0);
      tick();
      n_checks++;
      if (bus.out_valid !== (mq.size() != 0) ||
          bus.out_data !== m_head() ||
          almost_full !== m_af() || overflow !== m_ovf ||
          skew_err !== m_skew || rows_out !== m_rows) begin
        n_fail++;
        $display("FAIL rand cyc=%0d got v=%b d=%h af=%b o=%b s=%b n=%0d want v=%b d=%h af=%b o=%b s=%b n=%0d",
                 cyc, bus.out_valid, bus.out_data, almost_full,
                 overflow, skew_err, rows_out, (mq.size() != 0),
                 m_head(), m_af(), m_ovf, m_skew, m_rows);
      end
    end
    clear_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [RW-1:0] row;
    int t0;
    bus.out_ready = 1'b0;
    t0 = cyc + COLS;
    issue(t0, '1, rand_row());
    issue(t0 + 1, '1, rand_row());
    issue(t0 + 2, 4'b0011, rand_row());
    while (cyc < t0 + 3 + COLS) tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || skew_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre got v=%b s=%b want 1/1",
               bus.out_valid, skew_err);
    end
    #2;
    rst = 1'b1;
    bus.col_valid = '0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      n_fail++;
      $display("FAIL rmid_async got v=%b d=%h want 0/0",
               bus.out_valid, bus.out_data);
    end
    n_checks++;
    if (rows_out !== 16'd0 ||
        {almost_full, overflow, skew_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL rmid_state got n=%0d f=%b want 0/000",
               rows_out, {almost_full, overflow, skew_err});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    row = rand_row();
    issue(cyc, '1, row);
    for (int i = 1; i <= COLS; i++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== (i == COLS)) begin
        n_fail++;
        $display("FAIL rmid_latency i=%0d got=%b want=%b",
                 i, bus.out_valid, (i == COLS));
      end
    end
    n_checks++;
    if (bus.out_data !== row) begin
      n_fail++;
      $display("FAIL rmid_data got=%h want=%h",
               bus.out_data, row);
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_backpressure();
    test_full_pushpop();
    test_skew_err();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
endmodule
